// File: rtl/alu_mult_ctrl.sv
// Shift-and-add multiplier controller wrapped around an external combinational 32-bit ALU.
// Optional signed-operand support (sgn port, FIX state) is built when MULT_SIGNED_EN is defined.
module alu_mult_ctrl #(
  parameter logic [2:0] ADD_OP = 3'b010
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] mcand,
  input  logic [31:0] mplier,
`ifdef MULT_SIGNED_EN
  input  logic        sgn,
`endif
  input  logic [31:0] alu_result,
  input  logic        alu_c_out,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [63:0] product,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_oper
);

`ifdef MULT_SIGNED_EN
  typedef enum logic [1:0] {IDLE, ITER, FIX, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;
`endif

  state_t      state_q, state_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] mc_q, mc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] product_q, product_d;
  logic [63:0] step;
`ifdef MULT_SIGNED_EN
  logic        neg_q, neg_d;
  logic [63:0] fixed;

  // 0x80000000 maps to itself, which is the correct unsigned magnitude 2^31.
  function automatic logic [31:0] mag32(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] v);
    return ~v + 64'd1;
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      hi_q      <= '0;
      lo_q      <= '0;
      mc_q      <= '0;
      cnt_q     <= '0;
      product_q <= '0;
`ifdef MULT_SIGNED_EN
      neg_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      mc_q      <= mc_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
`ifdef MULT_SIGNED_EN
      neg_q     <= neg_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    mc_d      = mc_q;
    cnt_d     = cnt_q;
    product_d = product_q;
`ifdef MULT_SIGNED_EN
    neg_d     = neg_q;
    fixed     = neg_q ? neg64({hi_q, lo_q}) : {hi_q, lo_q};
`endif
    ready     = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    alu_a     = '0;
    alu_b     = '0;
    alu_oper  = ADD_OP;
    // 65-bit {carry, sum, lo} shifted right by one place.
    step      = {alu_c_out, alu_result, lo_q[31:1]};

    case (state_q)
      IDLE: begin
        ready = 1'b1;
        busy  = 1'b0;
        if (start) begin
          hi_d      = '0;
          cnt_d     = '0;
          product_d = '0;
          state_d   = ITER;
`ifdef MULT_SIGNED_EN
          if (sgn) begin
            mc_d  = mag32(mcand);
            lo_d  = mag32(mplier);
            neg_d = mcand[31] ^ mplier[31];
          end else begin
            mc_d  = mcand;
            lo_d  = mplier;
            neg_d = 1'b0;
          end
`else
          mc_d = mcand;
          lo_d = mplier;
`endif
        end
      end
      ITER: begin
        alu_a        = hi_q;
        alu_b        = lo_q[0] ? mc_q : 32'd0;
        {hi_d, lo_d} = step;
        cnt_d        = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
`ifdef MULT_SIGNED_EN
          state_d = FIX;
`else
          product_d = step;
          state_d   = DONE;
`endif
        end
      end
`ifdef MULT_SIGNED_EN
      FIX: begin
        {hi_d, lo_d} = fixed;
        product_d    = fixed;
        state_d      = DONE;
      end
`endif
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign product = product_q;

endmodule

// File: tb/tb_alu_mult_ctrl.sv
// Self-checking bench for alu_mult_ctrl: closes the loop with an ADD-only ALU model,
// runs a vector table, hand sequences for hold/reset corners, and randomized operands.
module tb_alu_mult_ctrl;

`ifdef MULT_SIGNED_EN
  localparam int LAT = 34;
`else
  localparam int LAT = 33;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] mcand, mplier;
`ifdef MULT_SIGNED_EN
  logic        sgn;
`endif
  logic [31:0] alu_result;
  logic        alu_c_out;
  logic        ready, busy, done;
  logic [63:0] product;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_oper;

  int total = 0;
  int passed = 0;

  alu_mult_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .mcand(mcand), .mplier(mplier),
`ifdef MULT_SIGNED_EN
    .sgn(sgn),
`endif
    .alu_result(alu_result), .alu_c_out(alu_c_out),
    .ready(ready), .busy(busy), .done(done), .product(product),
    .alu_a(alu_a), .alu_b(alu_b), .alu_oper(alu_oper)
  );

  always #5 clk = ~clk;

  // External ALU: adds only when given the ADD opcode.
  always_comb begin
    if (alu_oper == 3'b010) {alu_c_out, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
    else                    {alu_c_out, alu_result} = 33'd0;
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [63:0] exp;
    bit          zero_b;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: actual=%h required=%h", nm, act, exp);
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  // Called at a negedge where the block should be ready; returns at the negedge after done.
  task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic [63:0] exp, input bit hold, input bit zero_b);
    int  k;
    bit  got, busy_ok, zb_ok, cleared_ok;
    chk({nm, "_ready_at_start"}, 64'(ready), 64'd1);
    mcand = a; mplier = b; start = 1'b1;
`ifdef MULT_SIGNED_EN
    sgn = s;
`endif
    k = 0; got = 0; busy_ok = 1; zb_ok = 1; cleared_ok = 1;
    while (k < 60 && !got) begin
      @(negedge clk);
      k++;
      if (hold) begin
        mcand = $urandom; mplier = $urandom;
`ifdef MULT_SIGNED_EN
        sgn = ~s;
`endif
      end else start = 1'b0;
      if (done) got = 1;
      else begin
        if (!(busy === 1'b1 && ready === 1'b0 && alu_oper === 3'b010)) busy_ok = 0;
        if (zero_b && k <= 32 && alu_b !== 32'd0) zb_ok = 0;
        if (k == 1 && product !== 64'd0) cleared_ok = 0;
      end
    end
    chk({nm, "_latency"}, got ? 64'(k) : 64'd999, 64'(LAT));
    chk({nm, "_busy_window"}, 64'(busy_ok), 64'd1);
    chk({nm, "_product_cleared"}, 64'(cleared_ok), 64'd1);
    if (zero_b) chk({nm, "_alu_b_zero"}, 64'(zb_ok), 64'd1);
    chk({nm, "_product"}, product, exp);
    @(negedge clk);
    chk({nm, "_single_done"}, 64'(done), 64'd0);
    chk({nm, "_ready_after"}, 64'({ready, busy}), 64'b10);
    chk({nm, "_product_held"}, product, exp);
    start = 1'b0;
  endtask

  initial begin
    int ndone;
    logic [31:0] ra, rb;
    logic        rs;
    reset = 1'b1; start = 1'b0; mcand = '0; mplier = '0;
`ifdef MULT_SIGNED_EN
    sgn = 1'b0;
`endif

    vecs.push_back('{32'd3, 32'd7, 1'b0, 64'd21, 1'b0});
    vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001, 1'b0});
    vecs.push_back('{32'd0, 32'h12345678, 1'b0, 64'd0, 1'b1});
    vecs.push_back('{32'h80000000, 32'd2, 1'b0, 64'h1_00000000, 1'b0});
    vecs.push_back('{32'd1, 32'hFFFFFFFF, 1'b0, 64'h0_FFFFFFFF, 1'b0});
`ifdef MULT_SIGNED_EN
    vecs.push_back('{32'hFFFFFFFD, 32'd7, 1'b1, 64'hFFFFFFFF_FFFFFFEB, 1'b0});
    vecs.push_back('{32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000, 1'b0});
    vecs.push_back('{32'hFFFFFFFF, 32'd2, 1'b0, 64'h1_FFFFFFFE, 1'b0});
    vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'd1, 1'b0});
`endif

    @(negedge clk);
    @(negedge clk);
    chk("reset_outputs", {ready, busy, done, alu_oper}, {1'b1, 1'b0, 1'b0, 3'b010});
    chk("reset_alu_ops", {alu_a, alu_b}, 64'd0);
    chk("reset_product", product, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].exp, 1'b0, vecs[i].zero_b);

    // Start held high with changing operands; the next op chains at the ready cycle.
    run_op("hold", 32'd3, 32'd7, 1'b0, 64'd21, 1'b1, 1'b0);
    run_op("chain", 32'd11, 32'd13, 1'b0, 64'd143, 1'b0, 1'b0);

    // Reset mid-operation at ITER cycle 10.
    mcand = 32'd9; mplier = 32'd9; start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset_state", {ready, busy, done}, 3'b100);
    chk("midreset_product", product, 64'd0);
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("midreset_no_done", 64'(ndone), 64'd0);
    run_op("after_reset", 32'd5, 32'd5, 1'b0, 64'd25, 1'b0, 1'b0);

    // Start coincident with reset is dropped.
    reset = 1'b1; start = 1'b1; mcand = 32'd3; mplier = 32'd3;
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("start_with_reset", {ready, busy}, 2'b10);

    for (int i = 0; i < 16; i++) begin
      ra = $urandom; rb = $urandom;
`ifdef MULT_SIGNED_EN
      rs = 1'($urandom_range(0, 1));
`else
      rs = 1'b0;
`endif
      if (i == 0) ra = 32'h80000000;
      run_op($sformatf("rand%0d", i), ra, rb, rs, model(ra, rb, rs), 1'b0, 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_mult_ctrl.md
# alu_mult_ctrl

Sequential shift-and-add multiplier controller that sits directly upstream and downstream of the 32-bit ALU. It drives the ALU operand and opcode inputs and consumes `alu_result` and `alu_c_out`. It iterates 32 add/shift steps to form a 64-bit product. The ALU itself stays combinational. This block adds the state, the counter, the start/done handshake and the product registers.

## Interface
Clock is `clk`. Reset is `reset`: synchronous and active-high. Reset is sampled only on the rising edge of `clk`.

Parameters:
- `ADD_OP`, default 3'b010: ALU opcode driven for every iteration (ALU ADD).

Ports:
- `clk`  input  1  rising-edge clock
- `reset`  input  1  synchronous, active-high reset
- `start`  input  1  request a multiply; sampled only when `ready`=1
- `mcand`  input  32  multiplicand; captured on an accepted start
- `mplier`  input  32  multiplier; captured on an accepted start
- `sgn`  input  1  signed-operand select; exists only when MULT_SIGNED_EN is defined
- `alu_result`  input  32  ALU sum output
- `alu_c_out`  input  1  ALU carry out of bit 31
- `ready`  output  1  high in IDLE only
- `busy`  output  1  high in every non-IDLE state
- `done`  output  1  one-cycle pulse: product is valid
- `product`  output  64  result, held until the next accepted start or reset
- `alu_a`  output  32  ALU operand a
- `alu_b`  output  32  ALU operand b
- `alu_oper`  output  3  ALU opcode; always `ADD_OP`

## Operation
- **States:** IDLE, ITER, FIX (MULT_SIGNED_EN builds only), DONE.
- **Registers:** `hi[31:0]`, `lo[31:0]`, `mc[31:0]`, 5-bit `cnt`, and a sign flag `neg` (signed builds only).
- **IDLE:**
  - If `start`=1: `mc`←`mcand`, `lo`←`mplier`, `hi`←0, `cnt`←0, next state ITER.
  - If `start`=0: remain in IDLE.
- **ITER, every cycle:**
  - Combinational drive: `alu_a`=`hi`, `alu_b`=`lo[0]` ? `mc` : 0, `alu_oper`=`ADD_OP`.
  - Register update: {`hi`,`lo`} ← {`alu_c_out`, `alu_result`, `lo[31:1]`}, i.e. the 65-bit value shifted right by one.
  - `cnt` increments each cycle. When `cnt`=31, the next state is FIX (signed builds) or DONE.
  - `cnt` wraps 31→0 and is never read outside ITER.
- **FIX (signed builds only):** if `neg`=1, {`hi`,`lo`} ← two's complement of {`hi`,`lo`}, computed locally without the ALU. Next state DONE.
- **DONE:**
  - `done`=1 and `product`={`hi`,`lo`}.
  - Next state is IDLE unconditionally.
  - `start` is ignored in DONE; it must be reasserted once `ready`=1.
- **Outside ITER:** `alu_a`=0, `alu_b`=0, `alu_oper`=`ADD_OP`.
- **`start` while `busy`=1:** ignored. Operands are not recaptured and the running operation is unaffected.
- **Reset behaviour:**
  - Registers on reset: `product`=0, `hi`=`lo`=`mc`=0, `cnt`=0, `neg`=0, state IDLE.
  - Output values on reset: `ready`=1, `busy`=0, `done`=0, `alu_a`=`alu_b`=0, `alu_oper`=`ADD_OP`.
  - Reset asserted mid-operation aborts it. The cycle after reset is IDLE, `product` is 0, and no `done` pulse is produced.
  - `start` asserted in the same cycle as `reset` is ignored.

## Timing
- An accepted start in cycle N puts the block in ITER for cycles N+1 … N+32.
- Unsigned build: `done`=1 in cycle N+33.
- Signed build: FIX in cycle N+33 and `done`=1 in cycle N+34. Latency is constant and independent of operand signs.
- `ready` returns to 1 in the cycle after `done`. The earliest next accept is therefore N+34 (unsigned) or N+35 (signed).
- `product` is registered. It updates in the DONE cycle and is stable until the next accepted start clears it.
- The combinational ALU path (`alu_a`/`alu_b` out, `alu_result`/`alu_c_out` back) must settle within one `clk` period.

## Configuration
- **MULT_SIGNED_EN defined:**
  - The `sgn` port and the FIX state exist.
  - On accept with `sgn`=1: `mc`←|`mcand`|, `lo`←|`mplier`| (local negation), and `neg`←`mcand[31]` XOR `mplier[31]`.
  - With `sgn`=0: behaviour is identical to unsigned, except that FIX is still traversed (no-op) to keep latency constant.
  - Magnitude of 0x80000000 is 0x80000000, treated as an unsigned 2^31.
- **MULT_SIGNED_EN undefined:** no `sgn` port, no FIX state, unsigned only, 33-cycle latency.

## Test plan
- **Basic multiply:** `mcand`=3, `mplier`=7, start at N → `done` at N+33, `product`=64'd21, `busy`=1 for N+1…N+32, then `ready`=1 at N+34.
- **Carry path:** `mcand`=`mplier`=32'hFFFFFFFF → `product`=64'hFFFFFFFE_00000001. This exercises `alu_c_out` on each iteration.
- **Zero operand:** `mcand`=0, `mplier`=32'h12345678 → `product`=0. Check that `alu_b`=0 on every ITER cycle.
- **Busy and repeat handling:** `start` held high throughout an op with new operands → original result unchanged, exactly one `done`. A second op is accepted at N+34.
- **Reset mid-operation:** reset asserted at ITER cycle 10 → next cycle IDLE, `product`=0, `busy`=0, no `done`. A following 5×5 returns 64'd25.
- **Signed cases (MULT_SIGNED_EN builds):**
  - `sgn`=1, -3×7 → 64'hFFFFFFFF_FFFFFFEB at N+34.
  - 0x80000000×0x80000000 → 64'h40000000_00000000.
  - `sgn`=0, 0xFFFFFFFF×2 → 64'h1_FFFFFFFE.
